load_converter_unit: RTL and testbench
======================================

Name: load_converter_unit

Overview:
- Load-side counterpart of the store converter in the Writeback Cycle.
- Accepts a load request and issues a word-aligned read to data memory over a ready handshake.
- Extracts the addressed byte, halfword or word and sign- or zero-extends it.
- Returns a registered 32-bit result with a one-cycle valid pulse; flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT, 16, maximum cycles to wait for mem_ready after mem_read asserts before aborting.
CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  load request; sampled only when busy=0
aluSelect  input  6  load type: 001000 LB, 001001 LH, 001010 LW, 001011 LBU, 001100 LHU; other codes are not loads
address  input  32  byte address of the load
busy  output  1  high while a request is in flight (state != IDLE)
mem_read  output  1  memory read strobe
mem_addr  output  32  word-aligned read address, {address[31:2],2'b00}
mem_rdata  input  32  memory read data; valid when mem_ready=1
mem_ready  input  1  memory response strobe
outputData  output  32  extended load result
result_valid  output  1  one-cycle pulse: outputData is valid
misaligned  output  1  one-cycle pulse: request rejected for alignment
bus_error  output  1  one-cycle pulse: memory timeout

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; busy, mem_read, result_valid, misaligned and bus_error all 0.
  - mem_addr=0, outputData=0, timeout counter=0.
  - Reset mid-transaction aborts with no result or error pulse; the next request is accepted normally.
- State IDLE:
  - Acts only if load_valid=1 and aluSelect is a load code; otherwise stays in IDLE. Non-load codes are ignored with no pulse.
  - Latches the type and offset address[1:0].
  - If LH/LHU with address[0]=1, or LW with address[1:0]!=0: misaligned=1 on the next cycle, outputData=0, no memory access, remain IDLE.
  - Otherwise go to REQ with mem_read=1, mem_addr=aligned address, counter=0.
- State REQ:
  - mem_read and mem_addr are held stable until mem_ready=1.
  - On mem_ready=1:
    - Register the extracted and extended mem_rdata into outputData.
    - Pulse result_valid=1 in the following cycle, deassert mem_read, go to IDLE.
  - If mem_ready=1 arrives in the same cycle mem_read first asserts, it is accepted, giving minimum latency of 2 cycles from request to result_valid.
  - If mem_ready=0, increment the counter. When counter==TIMEOUT-1 with no ready: bus_error=1 next cycle, outputData=0, mem_read=0, go to IDLE.
  - If mem_ready and the timeout coincide, mem_ready wins.
- Extraction, little-endian, off = latched address[1:0]:
  - byte = mem_rdata[8*off+7 : 8*off]
  - half = mem_rdata[16*off[1]+15 : 16*off[1]]
  - LB: sign-extend byte. LBU: zero-extend byte.
  - LH: sign-extend half. LHU: zero-extend half.
  - LW: pass through unchanged.
- Pulses and output hold:
  - result_valid, misaligned and bus_error are mutually exclusive single-cycle pulses.
  - outputData holds its last value until the next completion.
- Spurious mem_ready in IDLE is ignored.
- load_valid while busy=1 is ignored; the requester must hold load_valid until busy=0.
- Back-to-back requests: a new request may be accepted in the cycle result_valid pulses, since state is already IDLE.

Test Plan:
- LB at 0x1003, mem_rdata=0x80FF_1234, ready after 1 cycle -> mem_addr=0x1000; result_valid pulse; outputData=0xFFFF_FF80.
- LBU at 0x1003 with the same data -> outputData=0x0000_0080. LHU at 0x1002 -> 0x0000_80FF. LH at 0x1000 -> 0x0000_1234.
- LW at 0x2000, mem_ready held low for 3 cycles -> mem_read=1 and mem_addr=0x2000 stable for 4 cycles; outputData=mem_rdata; busy falls the cycle result_valid pulses.
- LH at 0x1001, then LW at 0x1002 -> misaligned pulse each time; mem_read never asserts; outputData=0.
- LW with mem_ready never asserted, TIMEOUT=16 -> bus_error pulse exactly 16 cycles after mem_read first rises; mem_read=0 after.
- reset=1 for one cycle while in REQ -> every output 0 the next cycle; a following LBU at 0x0 with mem_rdata=0xAB completes with outputData=0x0000_00AB.

Source files
------------

// File: rtl/load_converter_if.sv
// Load request and data-memory read channel bundled for the load converter.
// slave: converter side; master: requester/memory side.
interface load_converter_if;
    logic        load_valid;
    logic [5:0]  aluSelect;
    logic [31:0] address;
    logic        busy;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] outputData;
    logic        result_valid;
    logic        misaligned;
    logic        bus_error;

    modport slave (
        input  load_valid, aluSelect, address, mem_rdata, mem_ready,
        output busy, mem_read, mem_addr, outputData, result_valid, misaligned, bus_error
    );

    modport master (
        output load_valid, aluSelect, address, mem_rdata, mem_ready,
        input  busy, mem_read, mem_addr, outputData, result_valid, misaligned, bus_error
    );
endinterface

// File: rtl/load_converter_unit.sv
// Load converter: word-aligned memory read, byte/half/word extract and extend.
// Latency >= 2 cycles request->result_valid; holds mem_read until mem_ready or TIMEOUT.
module load_converter_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    load_converter_if.slave   bus
);
    localparam logic [5:0] SEL_LB  = 6'b001000;
    localparam logic [5:0] SEL_LH  = 6'b001001;
    localparam logic [5:0] SEL_LW  = 6'b001010;
    localparam logic [5:0] SEL_LBU = 6'b001011;
    localparam logic [5:0] SEL_LHU = 6'b001100;

    typedef enum logic {IDLE, REQ} state_t;

    state_t      r_state,    w_state_nxt;
    logic [5:0]  r_sel,      w_sel_nxt;
    logic [1:0]  r_off,      w_off_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic        r_mem_read, w_mem_read_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_data,     w_data_nxt;
    logic        r_rv,       w_rv_nxt;
    logic        r_mis,      w_mis_nxt;
    logic        r_be,       w_be_nxt;

    logic        w_is_load;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_is_load = (bus.aluSelect == SEL_LB)  || (bus.aluSelect == SEL_LH) ||
                       (bus.aluSelect == SEL_LW)  || (bus.aluSelect == SEL_LBU) ||
                       (bus.aluSelect == SEL_LHU);

    assign w_misalign = (((bus.aluSelect == SEL_LH) || (bus.aluSelect == SEL_LHU)) && bus.address[0]) ||
                        ((bus.aluSelect == SEL_LW) && (bus.address[1:0] != 2'b00));

    // Little-endian lane select uses the offset latched at request time.
    assign w_byte = 8'(bus.mem_rdata >> {r_off, 3'b000});
    assign w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        w_ext = bus.mem_rdata;
        case (r_sel)
            SEL_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
            SEL_LBU: w_ext = {24'h0, w_byte};
            SEL_LH:  w_ext = {{16{w_half[15]}}, w_half};
            SEL_LHU: w_ext = {16'h0, w_half};
            default: w_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_off_nxt      = r_off;
        w_cnt_nxt      = r_cnt;
        w_mem_read_nxt = r_mem_read;
        w_mem_addr_nxt = r_mem_addr;
        w_data_nxt     = r_data;
        w_rv_nxt       = 1'b0;
        w_mis_nxt      = 1'b0;
        w_be_nxt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load_valid && w_is_load) begin
                    w_sel_nxt = bus.aluSelect;
                    w_off_nxt = bus.address[1:0];
                    if (w_misalign) begin
                        w_mis_nxt  = 1'b1;
                        w_data_nxt = 32'h0;
                    end else begin
                        w_state_nxt    = REQ;
                        w_mem_read_nxt = 1'b1;
                        w_mem_addr_nxt = {bus.address[31:2], 2'b00};
                        w_cnt_nxt      = '0;
                    end
                end
            end
            REQ: begin
                // mem_ready takes priority over a coincident timeout.
                if (bus.mem_ready) begin
                    w_data_nxt     = w_ext;
                    w_rv_nxt       = 1'b1;
                    w_mem_read_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_be_nxt       = 1'b1;
                    w_data_nxt     = 32'h0;
                    w_mem_read_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_off      <= '0;
            r_cnt      <= '0;
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
            r_data     <= '0;
            r_rv       <= 1'b0;
            r_mis      <= 1'b0;
            r_be       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_off      <= w_off_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mem_read <= w_mem_read_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_data     <= w_data_nxt;
            r_rv       <= w_rv_nxt;
            r_mis      <= w_mis_nxt;
            r_be       <= w_be_nxt;
        end
    end

    assign bus.busy         = (r_state != IDLE);
    assign bus.mem_read     = r_mem_read;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.outputData   = r_data;
    assign bus.result_valid = r_rv;
    assign bus.misaligned   = r_mis;
    assign bus.bus_error    = r_be;
endmodule

// File: tb/tb_load_converter_unit.sv
// Directed-vector bench for load_converter_unit: extraction, stall, misalign,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_load_converter_unit;
    localparam logic [5:0] LB  = 6'b001000;
    localparam logic [5:0] LH  = 6'b001001;
    localparam logic [5:0] LW  = 6'b001010;
    localparam logic [5:0] LBU = 6'b001011;
    localparam logic [5:0] LHU = 6'b001100;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    int          o_mr_cycles;
    int          o_rv;
    int          o_mis;
    int          o_be;
    int          o_busy;
    int          o_done;

    load_converter_if bus ();

    load_converter_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and play memory: ready comes after dly mem_read cycles.
    task automatic do_load(input logic [5:0] sel, input logic [31:0] addr,
                           input logic [31:0] rdata, input int dly,
                           input logic [31:0] exp_maddr);
        bus.load_valid = 1'b1;
        bus.aluSelect  = sel;
        bus.address    = addr;
        step();
        bus.load_valid = 1'b0;
        o_mr_cycles = 0;
        o_done = 0;
        for (int k = 0; k < 40 && o_done == 0; k++) begin
            if (bus.result_valid || bus.misaligned || bus.bus_error) begin
                o_done = 1;
            end else begin
                if (bus.mem_read) begin
                    o_mr_cycles++;
                    if (bus.mem_addr !== exp_maddr)
                        chk("mem_addr_stable", bus.mem_addr, exp_maddr);
                    bus.mem_ready = (o_mr_cycles > dly);
                    bus.mem_rdata = rdata;
                end
                step();
                bus.mem_ready = 1'b0;
            end
        end
        chk("wait_bound", 32'(o_done), 32'd1);
        o_rv   = int'(bus.result_valid);
        o_mis  = int'(bus.misaligned);
        o_be   = int'(bus.bus_error);
        o_busy = int'(bus.busy);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.load_valid = 1'b0;
        bus.aluSelect  = 6'b0;
        bus.address    = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.mem_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_busy",     32'(bus.busy), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_data",     bus.outputData, 32'h0);
        chk("rst_pulses",   32'({bus.result_valid, bus.misaligned, bus.bus_error}), 32'd0);

        // Non-load code and spurious mem_ready are ignored.
        bus.load_valid = 1'b1;
        bus.aluSelect  = 6'b000001;
        bus.mem_ready  = 1'b1;
        step();
        bus.load_valid = 1'b0;
        bus.mem_ready  = 1'b0;
        chk("nonload_busy",   32'(bus.busy), 32'd0);
        chk("nonload_pulses", 32'({bus.result_valid, bus.misaligned, bus.bus_error, bus.mem_read}), 32'd0);

        do_load(LB, 32'h1003, 32'h80FF_1234, 1, 32'h1000);
        chk("lb_rv",    32'(o_rv), 32'd1);
        chk("lb_mr",    32'(o_mr_cycles), 32'd2);
        chk("lb_data",  bus.outputData, 32'hFFFF_FF80);
        step();
        chk("lb_rv_single", 32'(bus.result_valid), 32'd0);
        chk("lb_hold",  bus.outputData, 32'hFFFF_FF80);

        do_load(LBU, 32'h1003, 32'h80FF_1234, 0, 32'h1000);
        chk("lbu_mr",   32'(o_mr_cycles), 32'd1);
        chk("lbu_data", bus.outputData, 32'h0000_0080);
        do_load(LHU, 32'h1002, 32'h80FF_1234, 0, 32'h1000);
        chk("lhu_data", bus.outputData, 32'h0000_80FF);
        do_load(LH, 32'h1000, 32'h80FF_1234, 0, 32'h1000);
        chk("lh_data",  bus.outputData, 32'h0000_1234);
        do_load(LH, 32'h1000, 32'h1234_8001, 0, 32'h1000);
        chk("lh_neg",   bus.outputData, 32'hFFFF_8001);
        do_load(LB, 32'h1001, 32'h1234_7F00, 0, 32'h1000);
        chk("lb_pos",   bus.outputData, 32'h0000_007F);

        do_load(LW, 32'h2000, 32'hDEAD_BEEF, 3, 32'h2000);
        chk("lw_mr",    32'(o_mr_cycles), 32'd4);
        chk("lw_rv",    32'(o_rv), 32'd1);
        chk("lw_busy",  32'(o_busy), 32'd0);
        chk("lw_data",  bus.outputData, 32'hDEAD_BEEF);

        do_load(LH, 32'h1001, 32'h0, 0, 32'h0);
        chk("mis_lh",    32'(o_mis), 32'd1);
        chk("mis_lh_mr", 32'(o_mr_cycles), 32'd0);
        chk("mis_lh_data", bus.outputData, 32'h0);
        do_load(LW, 32'h1002, 32'h0, 0, 32'h0);
        chk("mis_lw",    32'({o_mis[0], o_rv[0], o_be[0]}), 32'b100);
        chk("mis_lw_mr", 32'(o_mr_cycles), 32'd0);

        do_load(LW, 32'h3000, 32'h5555_AAAA, 0, 32'h3000);
        chk("pre_to_data", bus.outputData, 32'h5555_AAAA);
        do_load(LW, 32'h3004, 32'h0, 100, 32'h3004);
        chk("to_be",    32'({o_be[0], o_rv[0], o_mis[0]}), 32'b100);
        chk("to_cycles", 32'(o_mr_cycles), 32'd16);
        chk("to_mem_read", 32'(bus.mem_read), 32'd0);
        chk("to_data",  bus.outputData, 32'h0);

        do_load(LW, 32'h4000, 32'h1357_9BDF, 0, 32'h4000);
        bus.load_valid = 1'b1;
        bus.aluSelect  = LW;
        bus.address    = 32'h5000;
        step();
        bus.load_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_busy",  32'(bus.busy), 32'd0);
        chk("mrst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("mrst_mem_addr", bus.mem_addr, 32'h0);
        chk("mrst_data",  bus.outputData, 32'h0);
        chk("mrst_pulses", 32'({bus.result_valid, bus.misaligned, bus.bus_error}), 32'd0);
        do_load(LBU, 32'h0, 32'h0000_00AB, 0, 32'h0);
        chk("post_rst_rv",   32'(o_rv), 32'd1);
        chk("post_rst_data", bus.outputData, 32'h0000_00AB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
